mbs_fsk_sequencer: RTL and testbench

Controller that sequences the mbsFSK modulator datapath. It steps a 5-bit maximal-length LFSR, and each LFSR bit is one FSK symbol. A 7-bit down-counter times each symbol. The block generates the SHIFT strobe and the READY status. Firmware starts and stops bursts through a handshake gated by a firmware-ready flag. Outputs map to the user GPIO bank: ready, shift, lfsr, count.

---
 rtl/mbs_fsk_sequencer.sv | 139 +++++++++++++
 tb/tb_mbs_fsk_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbs_fsk_sequencer.sv
// Sequencer for the mbsFSK modulator: steps a maximal-length LFSR one bit per
// symbol, times each symbol with a down-counter and handles firmware start/stop.
module mbs_fsk_sequencer #(
  parameter int unsigned       LFSR_W = 5,
  parameter int unsigned       CNT_W  = 7,
  parameter int unsigned       NSYM_W = 8,
  parameter logic [LFSR_W-1:0] TAPS   = 5'b10100,
  parameter logic [LFSR_W-1:0] SEED   = 5'b00001
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              fw_rdy,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [NSYM_W-1:0] cfg_nsym,
  output logic              ready,
  output logic              busy,
  output logic              shift,
  output logic [LFSR_W-1:0] lfsr,
  output logic [CNT_W-1:0]  count,
  output logic              fsk_bit,
  output logic              done
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NSYM_W-1:0] SYM_ONE  = {{(NSYM_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOPPING
  } state_e;

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    div_l_q, div_l_d;
  logic [NSYM_W-1:0]   nsym_l_q, nsym_l_d;
  logic [NSYM_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic                stop_req_q, stop_req_d;
  logic                shift_q, shift_d;
  logic                done_q, done_d;
  logic                last_sym;
  logic                feedback;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED_EFF;
      count_q    <= '0;
      div_l_q    <= '0;
      nsym_l_q   <= '0;
      sym_cnt_q  <= '0;
      stop_req_q <= 1'b0;
      shift_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      count_q    <= count_d;
      div_l_q    <= div_l_d;
      nsym_l_q   <= nsym_l_d;
      sym_cnt_q  <= sym_cnt_d;
      stop_req_q <= stop_req_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
    end
  end

  // A burst length of zero means the burst only ends by stop or abort.
  assign last_sym = (nsym_l_q != '0) && (sym_cnt_q == (nsym_l_q - SYM_ONE));
  assign feedback = ^(lfsr_q & TAPS);

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    count_d    = count_q;
    div_l_d    = div_l_q;
    nsym_l_d   = nsym_l_q;
    sym_cnt_d  = sym_cnt_q;
    stop_req_d = stop_req_q;
    shift_d    = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && fw_rdy) begin
          div_l_d    = cfg_div;
          nsym_l_d   = cfg_nsym;
          lfsr_d     = SEED_EFF;
          count_d    = cfg_div;
          sym_cnt_d  = '0;
          stop_req_d = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN, S_STOPPING: begin
        if (!fw_rdy) begin
          state_d    = S_IDLE;
          count_d    = '0;
          stop_req_d = 1'b0;
        end else begin
          // A stop seen on a boundary cycle takes effect at the following boundary.
          if (stop) begin
            stop_req_d = 1'b1;
            state_d    = S_STOPPING;
          end
          if (count_q != '0) begin
            count_d = count_q - CNT_ONE;
          end else if (last_sym || stop_req_q) begin
            state_d    = S_IDLE;
            stop_req_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            lfsr_d    = {lfsr_q[LFSR_W-2:0], feedback};
            count_d   = div_l_q;
            sym_cnt_d = sym_cnt_q + SYM_ONE;
            shift_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready   = (state_q == S_IDLE);
    busy    = (state_q == S_RUN) || (state_q == S_STOPPING);
    fsk_bit = lfsr_q[0];
  end

  assign shift = shift_q;
  assign done  = done_q;
  assign lfsr  = lfsr_q;
  assign count = count_q;

endmodule

// File: tb/tb_mbs_fsk_sequencer.sv
// Bench for mbs_fsk_sequencer: fixed vector table, directed burst scenarios and
// a randomized run against a symbol-level reference model.
module tb_mbs_fsk_sequencer;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       fw_rdy = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [6:0] cfg_div = '0;
  logic [7:0] cfg_nsym = '0;
  logic       ready, busy, shift, fsk_bit, done;
  logic [4:0] lfsr;
  logic [6:0] count;

  int checks = 0;
  int errors = 0;

  // Reference model: burst position kept as symbol index and clock-within-symbol.
  logic [4:0] seq [31];
  bit         mRunning = 0;
  bit         mStopReq = 0;
  int         mDiv = 0, mNsym = 0, mPhase = 0, mSymIdx = 0;
  logic [4:0] mIdleLfsr = 5'b00001;
  bit         eShift = 0, eDone = 0;

  always #5 clk = ~clk;

  mbs_fsk_sequencer dut (
    .clk(clk), .rstb(rstb), .fw_rdy(fw_rdy), .start(start), .stop(stop),
    .cfg_div(cfg_div), .cfg_nsym(cfg_nsym), .ready(ready), .busy(busy),
    .shift(shift), .lfsr(lfsr), .count(count), .fsk_bit(fsk_bit), .done(done)
  );

  typedef struct {
    int r, f, s, p, d, n;
    int eReady, eShift, eDone, eLfsr, eCount;
  } vec_t;

  vec_t vecs [18];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [4:0] expLfsr();
    return mRunning ? seq[mSymIdx % 31] : mIdleLfsr;
  endfunction

  task automatic applyStimulus(input int r, input int f, input int s, input int p,
                               input int d, input int n);
    bit oldStop;
    rstb     = (r != 0);
    fw_rdy   = (f != 0);
    start    = (s != 0);
    stop     = (p != 0);
    cfg_div  = 7'(d);
    cfg_nsym = 8'(n);
    @(posedge clk);
    #1;
    eShift = 0;
    eDone  = 0;
    if (r == 0) begin
      mRunning  = 0;
      mStopReq  = 0;
      mIdleLfsr = 5'b00001;
    end else if (!mRunning) begin
      if (s != 0 && f != 0) begin
        mRunning = 1;
        mStopReq = 0;
        mDiv     = d;
        mNsym    = n;
        mPhase   = 0;
        mSymIdx  = 0;
      end
    end else if (f == 0) begin
      mIdleLfsr = seq[mSymIdx % 31];
      mRunning  = 0;
      mStopReq  = 0;
    end else begin
      oldStop = mStopReq;
      if (p != 0) mStopReq = 1;
      if (mPhase < mDiv) begin
        mPhase++;
      end else if ((mNsym != 0 && mSymIdx + 1 == mNsym) || oldStop) begin
        mIdleLfsr = seq[mSymIdx % 31];
        mRunning  = 0;
        mStopReq  = 0;
        eDone     = 1;
      end else begin
        mSymIdx++;
        mPhase = 0;
        eShift = 1;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [4:0] el;
    el = expLfsr();
    checkVal({tag, ".ready"}, 32'(ready), mRunning ? 0 : 1);
    checkVal({tag, ".busy"}, 32'(busy), mRunning ? 1 : 0);
    checkVal({tag, ".shift"}, 32'(shift), 32'(eShift));
    checkVal({tag, ".done"}, 32'(done), 32'(eDone));
    checkVal({tag, ".lfsr"}, 32'(lfsr), 32'(el));
    checkVal({tag, ".fsk_bit"}, 32'(fsk_bit), 32'(el[0]));
    checkVal({tag, ".count"}, 32'(count), mRunning ? (mDiv - mPhase) : 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busyCnt, shiftCnt, doneCnt, zeroSeen, shiftMiss, wrapAt, firstShift, extraShift, doneAt, stp;
    int shiftAt [4];
    logic [4:0] shiftLfsr [4];

    seq[0] = 5'b00001;
    for (int i = 1; i < 31; i++)
      seq[i] = {seq[i-1][3:0], ^(seq[i-1] & 5'b10100)};

    // r f s p div nsym | ready shift done lfsr count
    vecs[0]  = '{0, 1, 1, 0, 3, 4,  1, 0, 0, 1, 0};
    vecs[1]  = '{0, 1, 1, 0, 3, 4,  1, 0, 0, 1, 0};
    vecs[2]  = '{1, 0, 1, 0, 3, 4,  1, 0, 0, 1, 0};
    vecs[3]  = '{1, 1, 1, 1, 1, 2,  0, 0, 0, 1, 1};
    vecs[4]  = '{1, 1, 0, 0, 1, 2,  0, 0, 0, 1, 0};
    vecs[5]  = '{1, 1, 0, 0, 1, 2,  0, 1, 0, 2, 1};
    vecs[6]  = '{1, 1, 0, 0, 1, 2,  0, 0, 0, 2, 0};
    vecs[7]  = '{1, 1, 0, 0, 1, 2,  1, 0, 1, 2, 0};
    vecs[8]  = '{1, 1, 0, 0, 0, 0,  1, 0, 0, 2, 0};
    vecs[9]  = '{1, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0};
    vecs[10] = '{1, 1, 0, 0, 0, 0,  0, 1, 0, 2, 0};
    vecs[11] = '{1, 1, 0, 0, 0, 0,  0, 1, 0, 4, 0};
    vecs[12] = '{1, 1, 0, 1, 0, 0,  0, 1, 0, 9, 0};
    vecs[13] = '{1, 1, 0, 0, 0, 0,  1, 0, 1, 9, 0};
    vecs[14] = '{1, 1, 1, 0, 5, 0,  0, 0, 0, 1, 5};
    vecs[15] = '{1, 1, 0, 0, 5, 0,  0, 0, 0, 1, 4};
    vecs[16] = '{1, 0, 0, 0, 5, 0,  1, 0, 0, 1, 0};
    vecs[17] = '{1, 1, 0, 0, 5, 0,  1, 0, 0, 1, 0};

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].r, vecs[i].f, vecs[i].s, vecs[i].p, vecs[i].d, vecs[i].n);
      checkVal($sformatf("vec%0d.ready", i), 32'(ready), vecs[i].eReady);
      checkVal($sformatf("vec%0d.busy", i), 32'(busy), 1 - vecs[i].eReady);
      checkVal($sformatf("vec%0d.shift", i), 32'(shift), vecs[i].eShift);
      checkVal($sformatf("vec%0d.done", i), 32'(done), vecs[i].eDone);
      checkVal($sformatf("vec%0d.lfsr", i), 32'(lfsr), vecs[i].eLfsr);
      checkVal($sformatf("vec%0d.fsk_bit", i), 32'(fsk_bit), vecs[i].eLfsr % 2);
      checkVal($sformatf("vec%0d.count", i), 32'(count), vecs[i].eCount);
    end

    // Fixed burst: 4 symbols of 4 clocks.
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 3, 4);
    busyCnt = 0; shiftCnt = 0; doneCnt = 0;
    for (int i = 0; i < 4; i++) begin shiftAt[i] = -100; shiftLfsr[i] = '0; end
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) applyStimulus(1, 1, 0, 0, 3, 4);
      checkOutput("burst");
      if (busy) busyCnt++;
      if (shift) begin
        if (shiftCnt < 4) begin shiftAt[shiftCnt] = k; shiftLfsr[shiftCnt] = lfsr; end
        shiftCnt++;
      end
      if (done) begin doneCnt++; break; end
    end
    checkVal("burst.busy_cycles", busyCnt, 16);
    checkVal("burst.shifts", shiftCnt, 3);
    checkVal("burst.done_pulses", doneCnt, 1);
    checkVal("burst.gap1", shiftAt[1] - shiftAt[0], 4);
    checkVal("burst.gap2", shiftAt[2] - shiftAt[1], 4);
    checkVal("burst.lfsr1", 32'(shiftLfsr[0]), 2);
    checkVal("burst.lfsr2", 32'(shiftLfsr[1]), 4);
    checkVal("burst.lfsr3", 32'(shiftLfsr[2]), 9);
    applyStimulus(1, 1, 0, 0, 3, 4);
    checkVal("burst.after_ready", 32'(ready), 1);
    checkVal("burst.after_done", 32'(done), 0);

    // Continuous burst with one-clock symbols: full LFSR period.
    applyStimulus(1, 1, 1, 0, 0, 0);
    checkOutput("wrap_start");
    zeroSeen = 0; shiftMiss = 0; wrapAt = 0; shiftCnt = 0;
    for (int k = 0; k < 100; k++) begin
      applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("wrap");
      if (!shift) shiftMiss++; else shiftCnt++;
      if (lfsr == 5'b00000) zeroSeen++;
      if (lfsr == 5'b00001 && wrapAt == 0) wrapAt = shiftCnt;
    end
    checkVal("wrap.period", wrapAt, 31);
    checkVal("wrap.missing_shifts", shiftMiss, 0);
    checkVal("wrap.zero_states", zeroSeen, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("wrap_abort");

    // Graceful stop four clocks into the second symbol.
    applyStimulus(1, 1, 1, 0, 9, 0);
    checkOutput("stop_start");
    firstShift = 0; extraShift = 0; doneAt = 0;
    for (int k = 2; k <= 40; k++) begin
      stp = (firstShift > 0 && k == firstShift + 4) ? 1 : 0;
      applyStimulus(1, 1, 0, stp, 9, 0);
      checkOutput("stop");
      if (shift) begin
        if (firstShift == 0) firstShift = k; else extraShift++;
      end
      if (done) begin doneAt = k; break; end
    end
    checkVal("stop.first_shift", firstShift, 11);
    checkVal("stop.done_delay", doneAt - firstShift, 10);
    checkVal("stop.extra_shifts", extraShift, 0);
    checkVal("stop.lfsr_hold", 32'(lfsr), 2);

    // Config changes mid-burst are ignored; the next burst picks them up.
    applyStimulus(1, 1, 1, 0, 3, 3);
    shiftCnt = 0;
    for (int i = 0; i < 4; i++) shiftAt[i] = -100;
    for (int k = 2; k <= 40; k++) begin
      applyStimulus(1, 1, 0, 0, (k >= 3) ? 7 : 3, 3);
      checkOutput("cfg1");
      if (shift) begin
        if (shiftCnt < 4) shiftAt[shiftCnt] = k;
        shiftCnt++;
      end
      if (done) break;
    end
    checkVal("cfg1.first_shift", shiftAt[0], 5);
    checkVal("cfg1.period", shiftAt[1] - shiftAt[0], 4);
    applyStimulus(1, 1, 1, 0, 7, 2);
    firstShift = 0;
    for (int k = 2; k <= 40; k++) begin
      applyStimulus(1, 1, 0, 0, 7, 2);
      checkOutput("cfg2");
      if (shift && firstShift == 0) firstShift = k;
      if (done) break;
    end
    checkVal("cfg2.first_shift", firstShift, 9);

    // Randomized traffic including resets, aborts and stray start/stop.
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("rand_reset");
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom_range(0, 63) == 0) ? 0 : 1,
                    ($urandom_range(0, 31) == 0) ? 0 : 1,
                    ($urandom_range(0, 7) == 0) ? 1 : 0,
                    ($urandom_range(0, 15) == 0) ? 1 : 0,
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 5)));
      checkOutput("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
